expl_axi_sram: RTL and testbench
================================

# expl_axi_sram

Parametrised AXI3-style burst SRAM slave attached to the core's `expl_axi_*` external port, replacing the unconnected stub in the system top. Supports FIXED/INCR/WRAP bursts up to 16 beats, byte strobes, narrow transfers, per-beat range checking with DECERR, and fair arbitration between the read and write channels over a single-port memory. Sits between `e203_zs` and the board clock domain (`clk_16M` in the system top).

## Interface

- `ADDR_W`, 32, AXI address width (`E203_ADDR_SIZE`)
- `DATA_W`, 32, data width; 32 or 64 (`E203_XLEN`)
- `MEM_AW`, 12, log2 of memory depth in `DATA_W` words
- `BASE_ADDR`, 32'h2000_0000, byte base address; must be aligned to memory size

- `clk` in 1 — single clock
- `rst` in 1 — asynchronous, active-high reset
- `expl_axi_arvalid/arready` in/out 1; `araddr` in ADDR_W; `arcache` in 4, `arprot` in 3, `arlock` in 2 (ignored); `arburst` in 2; `arlen` in 4; `arsize` in 3
- `expl_axi_awvalid/awready` in/out 1; `awaddr` in ADDR_W; `awcache/awprot/awlock` ignored; `awburst` in 2; `awlen` in 4; `awsize` in 3
- `expl_axi_rvalid` out 1; `rready` in 1; `rdata` out DATA_W; `rresp` out 2; `rlast` out 1
- `expl_axi_wvalid` in 1; `wready` out 1; `wdata` in DATA_W; `wstrb` in DATA_W/8; `wlast` in 1
- `expl_axi_bvalid` out 1; `bready` in 1; `bresp` out 2

## Operation

- FSM states: IDLE, WR_DATA, WR_RESP, RD_FETCH, RD_DATA. One transaction at a time; no outstanding.
- IDLE arbitration: write wins if only awvalid; read wins if only arvalid; both valid → grant opposite of `last_grant` (reset value: read last, so write wins first). `awready`/`arready` high only in IDLE for the granted channel (combinational from valids).
- On AW/AR handshake latch addr, len, size, burst; beat counter = 0; error flag = 0.
- Error on accept (sticky per transaction, no memory effect for any beat): `burst`=2'b11, `size` > log2(DATA_W/8), WRAP with len not in {1,3,7,15}. Response SLVERR (2'b10).
- Per beat: address outside [BASE_ADDR, BASE_ADDR + 2^MEM_AW·DATA_W/8) → that beat DECERR (2'b11), write suppressed, rdata=0. Word index = (addr−BASE_ADDR) >> log2(DATA_W/8).
- Address advance, incr = 1<<size: FIXED unchanged; INCR addr+incr (no 4 KB check); WRAP bound=(len+1)·incr, addr = (addr & ~(bound−1)) | ((addr+incr) & (bound−1)).
- WR_DATA: `wready`=1; each handshake writes bytes enabled by `wstrb` (lane as presented; no realignment). Beat count==len → WR_RESP. `wlast` mismatch with count (early or missing) → bresp SLVERR; burst still ends at count==len.
- WR_RESP: `bvalid`=1, `bresp` = worst of OKAY < SLVERR < DECERR seen; held until `bready`; then IDLE, `last_grant`=write.
- RD_FETCH: issue synchronous memory read of current address → RD_DATA.
- RD_DATA: `rvalid`=1, `rdata` full word, `rresp` per beat (sticky SLVERR overrides), `rlast`=(count==len). Held stable until `rready`; then last → IDLE (`last_grant`=read), else advance → RD_FETCH.
- Memory contents not reset; read-during-write impossible (single transaction).

## Timing

- Reset: all ready/valid 0, `rdata`=0, `rresp`=0, `bresp`=0, `rlast`=0, state IDLE, `last_grant`=read.
- AW handshake cycle N → `wready` high N+1; write beats 1/cycle; last W at M → `bvalid` at M+1.
- AR handshake N → RD_FETCH N+1 → `rvalid` N+2; subsequent beats 2 cycles each with `rready` held high (len=3: rvalid at N+2,N+4,N+6,N+8).
- Back-to-back: next AW/AR accepted earliest the cycle after the B or final R handshake.
- `rst` mid-burst: immediately IDLE, outputs to reset values; writes already done persist; master must reissue.

## Test plan

- INCR write len=3 size=2 at 0x2000_0010, data 0x11..0x44, wstrb=4'hF; read back same → bresp 0, rdata 0x11,0x22,0x33,0x44, rlast on beat 4 only, rvalid at N+2,+4,+6,+8.
- WRAP read len=3 size=2 from 0x2000_0018 → word addresses 0x18,0x1C,0x10,0x14; FIXED write len=2 to 0x2000_0000 → memory holds final beat only.
- Byte strobes: write 0xAABBCCDD wstrb=4'b0101 over 0x0 → read 0x00BB00DD.
- Out-of-range INCR read starting at last word, len=1 → beat 1 OKAY with data, beat 2 DECERR rdata=0; write past end → bresp DECERR, in-range beat written.
- awvalid and arvalid both held asserted repeatedly → grants alternate W,R,W,R; rready toggling randomly → rdata/rresp/rlast stable while rvalid&!rready; arsize=3 with DATA_W=32 → SLVERR, memory unchanged.
- Assert `rst` during beat 2 of a len=7 write → all outputs 0 same cycle, beat 1 retained, new transaction accepted after release.

Source files
------------

// File: rtl/expl_axi_sram.sv
// AXI3 burst SRAM slave on the expl_axi port: FIXED/INCR/WRAP up to 16 beats, byte strobes, DECERR/SLVERR.
// One transaction at a time; W beats 1/cycle, R beats every 2 cycles; every channel stalls on its ready.
module expl_axi_sram #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MEM_AW    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h2000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  expl_axi_arvalid,
    output logic                  expl_axi_arready,
    input  logic [ADDR_W-1:0]     expl_axi_araddr,
    input  logic [3:0]            expl_axi_arcache,
    input  logic [2:0]            expl_axi_arprot,
    input  logic [1:0]            expl_axi_arlock,
    input  logic [1:0]            expl_axi_arburst,
    input  logic [3:0]            expl_axi_arlen,
    input  logic [2:0]            expl_axi_arsize,
    input  logic                  expl_axi_awvalid,
    output logic                  expl_axi_awready,
    input  logic [ADDR_W-1:0]     expl_axi_awaddr,
    input  logic [3:0]            expl_axi_awcache,
    input  logic [2:0]            expl_axi_awprot,
    input  logic [1:0]            expl_axi_awlock,
    input  logic [1:0]            expl_axi_awburst,
    input  logic [3:0]            expl_axi_awlen,
    input  logic [2:0]            expl_axi_awsize,
    output logic                  expl_axi_rvalid,
    input  logic                  expl_axi_rready,
    output logic [DATA_W-1:0]     expl_axi_rdata,
    output logic [1:0]            expl_axi_rresp,
    output logic                  expl_axi_rlast,
    input  logic                  expl_axi_wvalid,
    output logic                  expl_axi_wready,
    input  logic [DATA_W-1:0]     expl_axi_wdata,
    input  logic [DATA_W/8-1:0]   expl_axi_wstrb,
    input  logic                  expl_axi_wlast,
    output logic                  expl_axi_bvalid,
    input  logic                  expl_axi_bready,
    output logic [1:0]            expl_axi_bresp
);
    localparam int                BYTES     = DATA_W / 8;
    localparam int                BYTE_W    = $clog2(BYTES);
    localparam logic [2:0]        MAX_SIZE  = 3'(BYTE_W);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(1) << (MEM_AW + BYTE_W);
    localparam logic [1:0]        OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_FETCH, RD_DATA} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          len_q, cnt_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic                err_q, last_wr_q, rlast_q;
    logic [1:0]          wresp_q, bresp_q, rresp_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem [2**MEM_AW];

    logic [ADDR_W-1:0]   off, incr, mask, addr_d;
    logic [MEM_AW-1:0]   idx;
    logic                in_range, grant_wr, grant_rd;
    logic [1:0]          beat_resp, wbeat, wworst;

    logic unused_sideband;
    assign unused_sideband = ^{expl_axi_arcache, expl_axi_arprot, expl_axi_arlock,
                               expl_axi_awcache, expl_axi_awprot, expl_axi_awlock};

    function automatic logic req_err(input logic [1:0] burst, input logic [3:0] len,
                                     input logic [2:0] size);
        return (burst == 2'b11) || (size > MAX_SIZE) ||
               (burst == 2'b10 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    endfunction

    // Both valid: alternate away from whoever was served last.
    assign grant_wr = expl_axi_awvalid && (!expl_axi_arvalid || !last_wr_q);
    assign grant_rd = expl_axi_arvalid && !grant_wr;

    assign expl_axi_awready = (state_q == IDLE) && grant_wr;
    assign expl_axi_arready = (state_q == IDLE) && grant_rd;
    assign expl_axi_wready  = (state_q == WR_DATA);
    assign expl_axi_bvalid  = (state_q == WR_RESP);
    assign expl_axi_rvalid  = (state_q == RD_DATA);
    assign expl_axi_bresp   = bresp_q;
    assign expl_axi_rresp   = rresp_q;
    assign expl_axi_rdata   = rdata_q;
    assign expl_axi_rlast   = rlast_q;

    always_comb begin
        off       = addr_q - BASE_ADDR;
        in_range  = off < MEM_BYTES;
        idx       = off[MEM_AW+BYTE_W-1:BYTE_W];
        incr      = ADDR_W'(1) << size_q;
        mask      = ((ADDR_W'(len_q) + ADDR_W'(1)) * incr) - ADDR_W'(1);
        addr_d    = addr_q;
        case (burst_q)
            2'b01:   addr_d = addr_q + incr;
            2'b10:   addr_d = (addr_q & ~mask) | ((addr_q + incr) & mask);
            default: addr_d = addr_q;
        endcase
        beat_resp = err_q ? SLVERR : (in_range ? OKAY : DECERR);
        wbeat     = beat_resp;
        if ((expl_axi_wlast != (cnt_q == len_q)) && wbeat == OKAY)
            wbeat = SLVERR;
        wworst    = (wbeat > wresp_q) ? wbeat : wresp_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            last_wr_q <= 1'b0;
            wresp_q   <= OKAY;
            bresp_q   <= OKAY;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    wresp_q <= OKAY;
                    if (grant_wr) begin
                        addr_q  <= expl_axi_awaddr;
                        len_q   <= expl_axi_awlen;
                        size_q  <= expl_axi_awsize;
                        burst_q <= expl_axi_awburst;
                        err_q   <= req_err(expl_axi_awburst, expl_axi_awlen, expl_axi_awsize);
                        state_q <= WR_DATA;
                    end else if (grant_rd) begin
                        addr_q  <= expl_axi_araddr;
                        len_q   <= expl_axi_arlen;
                        size_q  <= expl_axi_arsize;
                        burst_q <= expl_axi_arburst;
                        err_q   <= req_err(expl_axi_arburst, expl_axi_arlen, expl_axi_arsize);
                        state_q <= RD_FETCH;
                    end
                end
                WR_DATA: begin
                    if (expl_axi_wvalid) begin
                        wresp_q <= wworst;
                        cnt_q   <= cnt_q + 4'd1;
                        addr_q  <= addr_d;
                        // Burst length comes from awlen; a bad wlast only taints the response.
                        if (cnt_q == len_q) begin
                            bresp_q <= wworst;
                            state_q <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (expl_axi_bready) begin
                        last_wr_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                RD_FETCH: begin
                    rdata_q <= (beat_resp == OKAY) ? mem[idx] : '0;
                    rresp_q <= beat_resp;
                    rlast_q <= (cnt_q == len_q);
                    state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (expl_axi_rready) begin
                        if (rlast_q) begin
                            last_wr_q <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            cnt_q   <= cnt_q + 4'd1;
                            addr_q  <= addr_d;
                            state_q <= RD_FETCH;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; reset only stops further writes via state_q.
    always_ff @(posedge clk) begin
        if (state_q == WR_DATA && expl_axi_wvalid && beat_resp == OKAY) begin
            for (int b = 0; b < BYTES; b++) begin
                if (expl_axi_wstrb[b])
                    mem[idx][8*b +: 8] <= expl_axi_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_expl_axi_sram.sv
// Directed bench for expl_axi_sram: write/read bursts, error responses, arbitration and mid-burst reset.
module tb_expl_axi_sram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arvalid = 0, arready, awvalid = 0, awready;
    logic [31:0] araddr = '0, awaddr = '0;
    logic [1:0]  arburst = 2'b01, awburst = 2'b01;
    logic [3:0]  arlen = '0, awlen = '0;
    logic [2:0]  arsize = 3'd2, awsize = 3'd2;
    logic        rvalid, rready = 0, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic        wvalid = 0, wready, wlast = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready = 0;

    int total = 0, bad = 0, cyc = 0, ar_cyc = 0;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd_dat [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    int          rd_cyc [16];

    typedef struct {
        string       nm;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] d [4];
        logic [1:0]  r [4];
    } rvec_t;
    rvec_t tbl [10];
    int    ntbl = 0;

    expl_axi_sram dut (
        .clk(clk), .rst(rst),
        .expl_axi_arvalid(arvalid), .expl_axi_arready(arready), .expl_axi_araddr(araddr),
        .expl_axi_arcache(4'h0), .expl_axi_arprot(3'h0), .expl_axi_arlock(2'h0),
        .expl_axi_arburst(arburst), .expl_axi_arlen(arlen), .expl_axi_arsize(arsize),
        .expl_axi_awvalid(awvalid), .expl_axi_awready(awready), .expl_axi_awaddr(awaddr),
        .expl_axi_awcache(4'h0), .expl_axi_awprot(3'h0), .expl_axi_awlock(2'h0),
        .expl_axi_awburst(awburst), .expl_axi_awlen(awlen), .expl_axi_awsize(awsize),
        .expl_axi_rvalid(rvalid), .expl_axi_rready(rready), .expl_axi_rdata(rdata),
        .expl_axi_rresp(rresp), .expl_axi_rlast(rlast),
        .expl_axi_wvalid(wvalid), .expl_axi_wready(wready), .expl_axi_wdata(wdata),
        .expl_axi_wstrb(wstrb), .expl_axi_wlast(wlast),
        .expl_axi_bvalid(bvalid), .expl_axi_bready(bready), .expl_axi_bresp(bresp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for handshake", nm);
    endtask

    task automatic aw_phase(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                            input logic [1:0] b);
        int t = 0;
        awvalid = 1; awaddr = a; awlen = l; awsize = s; awburst = b;
        #1;
        while (!awready && t < 50) begin step(); t++; end
        if (t >= 50) timeout("aw");
        step();
        awvalid = 0;
    endtask

    task automatic ar_phase(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                            input logic [1:0] b);
        int t = 0;
        arvalid = 1; araddr = a; arlen = l; arsize = s; arburst = b;
        #1;
        while (!arready && t < 50) begin step(); t++; end
        if (t >= 50) timeout("ar");
        step();
        arvalid = 0;
        ar_cyc = cyc;
    endtask

    // lmode: 0 = wlast on final beat, 1 = wlast on every beat, 2 = never wlast
    task automatic w_phase(input int n, input int lmode);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            wvalid = 1; wdata = wd[k]; wstrb = ws[k];
            wlast = (lmode == 0) ? (k == n - 1) : (lmode == 1);
            #1;
            while (!wready && t < 50) begin step(); t++; end
            if (t >= 50) timeout("w");
            step();
        end
        wvalid = 0; wlast = 0;
    endtask

    task automatic b_phase(output logic [1:0] resp);
        int t = 0;
        bready = 1;
        #1;
        while (!bvalid && t < 50) begin step(); t++; end
        if (t >= 50) timeout("b");
        resp = bresp;
        step();
        bready = 0;
    endtask

    task automatic r_phase(input int n, input bit rnd);
        int k = 0, t = 0;
        bit held = 0;
        logic [31:0] p_d;
        logic [1:0]  p_r;
        logic        p_l;
        while (k < n && t < 300) begin
            rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (rvalid) begin
                if (held) begin
                    chk("r_hold_data", rdata, p_d);
                    chk("r_hold_resp", 32'(rresp), 32'(p_r));
                    chk("r_hold_last", 32'(rlast), 32'(p_l));
                end
                if (rready) begin
                    rd_dat[k] = rdata; rd_resp[k] = rresp; rd_last[k] = rlast; rd_cyc[k] = cyc;
                    k++; held = 0;
                end else begin
                    held = 1; p_d = rdata; p_r = rresp; p_l = rlast;
                end
            end
            step();
            t++;
        end
        rready = 0;
        if (k < n) timeout("r");
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                            input logic [1:0] b, input int lmode, output logic [1:0] resp);
        aw_phase(a, l, s, b);
        chk("wready_after_aw", 32'(wready), 32'd1);
        w_phase(int'(l) + 1, lmode);
        chk("bvalid_after_wlast", 32'(bvalid), 32'd1);
        b_phase(resp);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                           input logic [1:0] b, input bit rnd);
        ar_phase(a, l, s, b);
        chk("rvalid_in_fetch", 32'(rvalid), 32'd0);
        r_phase(int'(l) + 1, rnd);
    endtask

    task automatic add(input string nm, input logic [31:0] a, input logic [3:0] l,
                       input logic [2:0] s, input logic [1:0] b,
                       input logic [31:0] d0, d1, d2, d3, input logic [1:0] r0, r1, r2, r3);
        tbl[ntbl].nm = nm; tbl[ntbl].addr = a; tbl[ntbl].len = l;
        tbl[ntbl].size = s; tbl[ntbl].burst = b;
        tbl[ntbl].d[0] = d0; tbl[ntbl].d[1] = d1; tbl[ntbl].d[2] = d2; tbl[ntbl].d[3] = d3;
        tbl[ntbl].r[0] = r0; tbl[ntbl].r[1] = r1; tbl[ntbl].r[2] = r2; tbl[ntbl].r[3] = r3;
        ntbl++;
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_arready"}, 32'(arready), 0);
        chk({nm, "_awready"}, 32'(awready), 0);
        chk({nm, "_wready"},  32'(wready), 0);
        chk({nm, "_bvalid"},  32'(bvalid), 0);
        chk({nm, "_rvalid"},  32'(rvalid), 0);
        chk({nm, "_rdata"},   rdata, 0);
        chk({nm, "_rresp"},   32'(rresp), 0);
        chk({nm, "_bresp"},   32'(bresp), 0);
        chk({nm, "_rlast"},   32'(rlast), 0);
    endtask

    initial begin
        logic [1:0] resp;
        string      gexp, gsee;

        add("incr4",      32'h2000_0010, 3, 2, 2'b01, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0);
        add("wrap4",      32'h2000_0018, 3, 2, 2'b10, 32'h33, 32'h44, 32'h11, 32'h22, 0, 0, 0, 0);
        add("strobe",     32'h2000_0000, 0, 2, 2'b01, 32'h00BB00DD, 0, 0, 0, 0, 0, 0, 0);
        add("oor_end",    32'h2000_3FFC, 1, 2, 2'b01, 32'hCAFE0001, 0, 0, 0, 0, 3, 0, 0);
        add("below_base", 32'h1FFF_FFFC, 0, 2, 2'b01, 0, 0, 0, 0, 3, 0, 0, 0);
        add("size8",      32'h2000_0010, 0, 3, 2'b01, 0, 0, 0, 0, 2, 0, 0, 0);
        add("burst3",     32'h2000_0010, 1, 2, 2'b11, 0, 0, 0, 0, 2, 2, 0, 0);
        add("wrap_len2",  32'h2000_0010, 2, 2, 2'b10, 0, 0, 0, 0, 2, 2, 2, 0);
        add("narrow_b",   32'h2000_0010, 3, 0, 2'b01, 32'h11, 32'h11, 32'h11, 32'h11, 0, 0, 0, 0);
        add("fixed_end",  32'h2000_3FFC, 1, 2, 2'b00, 32'hCAFE0001, 32'hCAFE0001, 0, 0, 0, 0, 0, 0);

        #1;
        chk_idle_outputs("reset");
        repeat (3) step();
        rst = 0;
        step();

        // INCR write then timed INCR read-back
        for (int k = 0; k < 4; k++) begin wd[k] = 32'h11 * (k + 1); ws[k] = 4'hF; end
        do_write(32'h2000_0010, 3, 2, 2'b01, 0, resp);
        chk("incr_bresp", 32'(resp), 0);
        do_read(32'h2000_0010, 3, 2, 2'b01, 0);
        for (int k = 0; k < 4; k++) begin
            chk("incr_rdata", rd_dat[k], 32'h11 * (k + 1));
            chk("incr_rlast", 32'(rd_last[k]), 32'(k == 3));
            chk("incr_rvalid_cycle", 32'(rd_cyc[k] - ar_cyc), 32'(1 + 2 * k));
        end

        // FIXED write leaves only the final beat
        wd[0] = 32'hA1; wd[1] = 32'hA2; wd[2] = 32'hA3; ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        do_write(32'h2000_0000, 2, 2, 2'b00, 0, resp);
        chk("fixed_bresp", 32'(resp), 0);
        do_read(32'h2000_0000, 0, 2, 2'b01, 0);
        chk("fixed_rdata", rd_dat[0], 32'hA3);

        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(32'h2000_0000, 0, 2, 2'b01, 0, resp);
        chk("strobe_bresp", 32'(resp), 0);

        wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h2000_3FFC, 1, 2, 2'b01, 0, resp);
        chk("oor_bresp", 32'(resp), 3);

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(32'h2000_0010, 0, 3, 2'b01, 0, resp);
        chk("size8_bresp", 32'(resp), 2);

        wd[0] = 32'h5; wd[1] = 32'h6;
        do_write(32'h2000_0020, 1, 2, 2'b01, 1, resp);
        chk("early_wlast_bresp", 32'(resp), 2);
        do_write(32'h2000_0020, 1, 2, 2'b01, 2, resp);
        chk("missing_wlast_bresp", 32'(resp), 2);

        for (int i = 0; i < ntbl; i++) begin
            do_read(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, bit'(i % 2));
            for (int k = 0; k <= int'(tbl[i].len); k++) begin
                chk({tbl[i].nm, "_rdata"}, rd_dat[k], tbl[i].d[k]);
                chk({tbl[i].nm, "_rresp"}, 32'(rd_resp[k]), 32'(tbl[i].r[k]));
                chk({tbl[i].nm, "_rlast"}, 32'(rd_last[k]), 32'(k == int'(tbl[i].len)));
            end
        end

        // Long random-rready read to exercise hold stability
        do_read(32'h2000_0010, 7, 2, 2'b01, 1);
        chk("rnd_beat0", rd_dat[0], 32'h11);
        chk("rnd_beat3", rd_dat[3], 32'h44);

        // Both address channels held: grants must alternate starting with write
        awaddr = 32'h2000_0040; awlen = 0; awsize = 2; awburst = 2'b01;
        araddr = 32'h2000_0010; arlen = 0; arsize = 2; arburst = 2'b01;
        wd[0] = 32'h77; ws[0] = 4'hF;
        awvalid = 1; arvalid = 1;
        gexp = "WRWR"; gsee = "";
        for (int g = 0; g < 4; g++) begin
            int t = 0;
            #1;
            while (!awready && !arready && t < 50) begin step(); t++; end
            if (t >= 50) timeout("arb");
            if (awready) begin
                gsee = {gsee, "W"};
                step();
                w_phase(1, 0);
                b_phase(resp);
            end else begin
                gsee = {gsee, "R"};
                step();
                r_phase(1, 0);
                chk("arb_rdata", rd_dat[0], 32'h11);
            end
        end
        awvalid = 0; arvalid = 0;
        total++;
        if (gsee != gexp) begin
            bad++;
            $display("FAIL arb_order: got %s want %s", gsee, gexp);
        end
        do_read(32'h2000_0040, 0, 2, 2'b01, 0);
        chk("arb_write_data", rd_dat[0], 32'h77);

        // Reset during beat 2 of a len=7 write
        wd[0] = 32'h5555_0000; wd[1] = 32'h5555_0001; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h2000_0080, 1, 2, 2'b01, 0, resp);
        chk("prefill_bresp", 32'(resp), 0);
        aw_phase(32'h2000_0080, 7, 2, 2'b01);
        wvalid = 1; wdata = 32'h100; wstrb = 4'hF; wlast = 0;
        #1;
        chk("rst_beat1_wready", 32'(wready), 1);
        step();
        wdata = 32'h101;
        rst = 1;
        #1;
        chk_idle_outputs("midrst");
        step();
        rst = 0; wvalid = 0;
        step();
        do_read(32'h2000_0080, 1, 2, 2'b01, 0);
        chk("midrst_beat1_kept", rd_dat[0], 32'h100);
        chk("midrst_beat2_dropped", rd_dat[1], 32'h5555_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
